// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin front end sharing one 4-bit arithmetic datapath.
// A single operation at a time runs IDLE -> EXEC (1..3 steps) -> DONE.
module alu_arbiter_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req0_x,
  input  logic [1:0] req0_mode,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [3:0] req1_x,
  input  logic [1:0] req1_mode,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [8:0] rsp_out,
  output logic       rsp_id,
  output logic       busy,
  output logic [7:0] ops_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d, b_q, b_d, x_q, x_d;
  logic [1:0] mode_q, mode_d;
  logic       id_q, id_d;
  logic [8:0] acc_q, acc_d;
  logic [8:0] rsp_q, rsp_d;
  logic [7:0] ops_q, ops_d;

  logic [8:0] step_res;
  logic [1:0] last_step;
  logic       gnt;

  // One datapath step; mode 11 builds 2*a*x+b over three steps in acc_q.
  always_comb begin
    step_res  = acc_q;
    last_step = 2'd0;
    case (mode_q)
      2'b00: step_res = {5'd0, a_q} + {5'd0, b_q};
      2'b01: step_res = {5'd0, a_q} - {5'd0, b_q};
      2'b10: begin
        step_res  = {5'd0, a_q} * {5'd0, b_q};
        last_step = 2'd1;
      end
      default: begin
        last_step = 2'd2;
        case (cnt_q)
          2'd0:    step_res = {5'd0, a_q} * {5'd0, x_q};
          2'd1:    step_res = {acc_q[7:0], 1'b0};
          default: step_res = acc_q + {5'd0, b_q};
        endcase
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    x_d        = x_q;
    mode_d     = mode_q;
    id_d       = id_q;
    acc_d      = acc_q;
    rsp_d      = rsp_q;
    ops_d      = ops_q;
    gnt        = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          // On a tie the requester not granted last time wins.
          gnt        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          req0_ready = ~gnt;
          req1_ready = gnt;
          last_d     = gnt;
          id_d       = gnt;
          a_d        = gnt ? req1_a : req0_a;
          b_d        = gnt ? req1_b : req0_b;
          x_d        = gnt ? req1_x : req0_x;
          mode_d     = gnt ? req1_mode : req0_mode;
          cnt_d      = 2'd0;
          state_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_d = step_res;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_step) begin
          rsp_d   = step_res;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          ops_d   = ops_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 2'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      x_q     <= 4'd0;
      mode_q  <= 2'd0;
      id_q    <= 1'b0;
      acc_q   <= 9'd0;
      rsp_q   <= 9'd0;
      ops_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
      acc_q   <= acc_d;
      rsp_q   <= rsp_d;
      ops_q   <= ops_d;
    end
  end

  assign rsp_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_out   = rsp_q;
  assign rsp_id    = id_q;
  assign ops_count = ops_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: directed steps plus random traffic, checked
// against a transaction-level model (arbitration, latency, result arithmetic).
module tb_alu_arbiter_ctrl;

  localparam int W = 10;  // {id, result}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req0_x = '0;
  logic [3:0] req1_a = '0, req1_b = '0, req1_x = '0;
  logic [1:0] req0_mode = '0, req1_mode = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [8:0] rsp_out;
  logic       rsp_id;
  logic       busy;
  logic [7:0] ops_count;

  alu_arbiter_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_x(req0_x), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_x(req1_x), .req1_mode(req1_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_id(rsp_id), .busy(busy), .ops_count(ops_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard and model state
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic       grants[$];
  bit         m_idle = 1'b1;
  bit         m_last = 1'b1;
  int         m_wait = 0;
  int         m_len  = 0;
  int         m_ops  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] calc(input logic [1:0] m, input int a, input int b, input int x);
    int r;
    case (m)
      2'd0:    r = a + b;
      2'd1:    r = a - b + 512;
      2'd2:    r = a * b;
      default: r = 2 * a * x + b;
    endcase
    return 9'(r % 512);
  endfunction

  function automatic int len_of(input logic [1:0] m);
    return (m < 2'd2) ? 1 : ((m == 2'd2) ? 2 : 3);
  endfunction

  task automatic model_reset();
    m_idle = 1'b1;
    m_last = 1'b1;
    m_wait = 0;
    m_ops  = 0;
    exp_q.delete();
    grants.delete();
  endtask

  // Check one settled cycle against the model, then advance the model past the edge.
  task automatic eval_cycle();
    logic       g;
    logic [3:0] a, b, x;
    logic [1:0] md;
    chk("ops_count", ops_count, m_ops % 256);
    if (m_idle) begin
      chk("busy_idle", busy, 0);
      chk("rsp_valid_idle", rsp_valid, 0);
      if (req0_valid || req1_valid) begin
        g = (req0_valid && req1_valid) ? !m_last : req1_valid;
        chk("req0_ready", req0_ready, !g);
        chk("req1_ready", req1_ready, g);
        a  = g ? req1_a : req0_a;
        b  = g ? req1_b : req0_b;
        x  = g ? req1_x : req0_x;
        md = g ? req1_mode : req0_mode;
        exp_q.push_back({g, calc(md, a, b, x)});
        grants.push_back(g);
        m_last = g;
        m_idle = 1'b0;
        m_wait = 1;
        m_len  = len_of(md);
      end else begin
        chk("req0_ready_none", req0_ready, 0);
        chk("req1_ready_none", req1_ready, 0);
      end
    end else begin
      chk("req0_ready_busy", req0_ready, 0);
      chk("req1_ready_busy", req1_ready, 0);
      chk("busy", busy, 1);
      if (m_wait <= m_len) begin
        chk("rsp_valid_exec", rsp_valid, 0);
        m_wait++;
      end else begin
        chk("rsp_valid_done", rsp_valid, 1);
        chk("rsp_out", rsp_out, exp_q[0][8:0]);
        chk("rsp_id", rsp_id, exp_q[0][9]);
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          m_idle = 1'b1;
          m_ops++;
        end
      end
    end
  endtask

  // Driver tasks
  task automatic run_cycle();
    #1;
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_operands();
    req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15));
    req0_x = 4'($urandom_range(0, 15)); req0_mode = 2'($urandom_range(0, 3));
    req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15));
    req1_x = 4'($urandom_range(0, 15)); req1_mode = 2'($urandom_range(0, 3));
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rand_operands();
  endtask

  task automatic drive_req(input logic id, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] x, input logic [1:0] md);
    idle_inputs();
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_x = x; req1_mode = md;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_x = x; req0_mode = md;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    #1;
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_out"}, rsp_out, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ops"}, ops_count, 0);
  endtask

  task automatic directed(input string tag, input logic id, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] x, input logic [1:0] md,
                          input int exp_val, input int exp_lat, input int stall);
    int cnt;
    logic [8:0] held;
    drive_req(id, a, b, x, md);
    rsp_ready = 1'b0;
    #1;
    chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    run_cycle();
    idle_inputs();
    cnt = 1;
    while (rsp_valid !== 1'b1 && cnt < 8) begin
      run_cycle();
      cnt++;
    end
    chk({tag, "_latency"}, cnt, exp_lat);
    chk({tag, "_out"}, rsp_out, exp_val);
    chk({tag, "_id"}, rsp_id, id);
    held = rsp_out;
    for (int s = 0; s < stall; s++) begin
      rand_operands();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      run_cycle();
    end
    if (stall > 0) chk({tag, "_stall_hold"}, rsp_out, held);
    idle_inputs();
    rsp_ready = 1'b1;
    run_cycle();
    rsp_ready = 1'b0;
    run_cycle();
  endtask

  // Stimulus
  initial begin
    int guard;
    rand_operands();
    do_reset();
    check_reset_values("reset");

    directed("add", 1'b0, 4'd9, 4'd7, 4'd0, 2'b00, 16, 2, 0);
    chk("add_ops", ops_count, 1);
    directed("sub", 1'b0, 4'd3, 4'd5, 4'd0, 2'b01, 510, 2, 0);
    directed("mul", 1'b0, 4'd15, 4'd15, 4'd0, 2'b10, 225, 3, 0);
    directed("mac_max", 1'b0, 4'd15, 4'd15, 4'd15, 2'b11, 465, 4, 0);
    directed("mac_small", 1'b0, 4'd2, 4'd1, 4'd3, 2'b11, 13, 4, 0);
    directed("stall", 1'b1, 4'd7, 4'd9, 4'd0, 2'b10, 63, 3, 5);
    chk("stall_ops", ops_count, 6);

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      rand_operands();
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      rsp_ready  = ($urandom_range(0, 3) != 0);
      run_cycle();
    end

    // Both requesters always valid: grants must alternate starting at 0
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_operands();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      run_cycle();
    end
    chk("tie_count", grants.size() >= 4, 1);
    if (grants.size() >= 4) begin
      chk("tie_g0", dut.req0_ready === 1'bx ? 2 : grants[0], 0);
      chk("tie_g1", grants[1], 1);
      chk("tie_g2", grants[2], 0);
      chk("tie_g3", grants[3], 1);
    end

    // 256 handshakes wrap ops_count
    do_reset();
    rsp_ready = 1'b1;
    guard = 0;
    while (m_ops < 256 && guard < 2000) begin
      rand_operands();
      req0_valid = 1'b1;
      req0_mode  = 2'b00;
      run_cycle();
      guard++;
    end
    chk("wrap_done", guard < 2000, 1);
    chk("wrap_ops", ops_count, 0);

    // Reset for one cycle in the middle of a mode 11 execute
    idle_inputs();
    while (!m_idle && guard < 2100) begin
      run_cycle();
      guard++;
    end
    drive_req(1'b0, 4'd15, 4'd15, 4'd15, 2'b11);
    run_cycle();
    idle_inputs();
    run_cycle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check_reset_values("midreset");
    for (int i = 0; i < 6; i++) run_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_ctrl.md
# alu_arbiter_ctrl

Controller that shares one 4-bit arithmetic datapath between two requesters. It round-robin arbitrates valid/ready command ports and sequences the selected operation over 1–3 execute cycles. It returns a 9-bit result tagged with the requester ID on a valid/ready response port. It sits between the command sources and the result consumer; only one operation is in flight at a time.

## Interface
- No parameters; all widths fixed.
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 command valid
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_a, req0_b, req0_x  in  4 each  requester 0 operands, unsigned
- req0_mode  in  2  requester 0 operation select
- req1_valid, req1_ready, req1_a, req1_b, req1_x, req1_mode  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_out  out  9  result
- rsp_id  out  1  requester that issued the result
- busy  out  1  high in any state other than IDLE
- ops_count  out  8  completed response handshakes, wraps modulo 256

## Operation
- Results, all mod 512, operands zero-extended:
  - mode 00 = a+b
  - mode 01 = a−b, two's complement, so 3−5 = 510
  - mode 10 = a*b
  - mode 11 = 2*a*x+b, with a maximum of 465
- x is used only in mode 11.
- FSM states:
  - IDLE: reqN_ready may assert.
  - EXEC: sub-step counter runs for L cycles.
  - DONE: rsp_valid held high.
- Transitions:
  - IDLE→EXEC on any accepted request.
  - EXEC→DONE when the sub-step counter reaches L−1.
  - DONE→IDLE on rsp_valid&&rsp_ready.
- Execute length L:
  - mode 00 and 01: L=1.
  - mode 10: L=2.
  - mode 11: L=3. Step 1 computes a*x, step 2 doubles it, step 3 adds b.
- Arbitration in IDLE:
  - If only one valid is high, that requester is granted.
  - If both are high, grant the requester not granted last.
  - The last-grant pointer updates only on acceptance.
- Ready rules:
  - Exactly one reqN_ready is high, combinationally in IDLE, only for the granted valid requester.
  - reqN_ready is 0 in EXEC and DONE.
- Operands, mode and ID are captured on the accept edge. Request inputs outside acceptance are ignored.
- Outputs in DONE:
  - rsp_out and rsp_id are stable from DONE entry until the handshake.
  - A requester's valid dropping after acceptance has no effect.
- ops_count increments on each rsp handshake; 255 increments to 0.
- Reset values, when rst_n is low at a clock edge:
  - state IDLE.
  - rsp_valid 0, rsp_out 0, rsp_id 0, busy 0, ops_count 0.
  - Last-grant pointer = 1, so requester 0 wins the first tie.
- Reset mid-operation aborts the in-flight operation. No response is produced and ops_count is not incremented.

## Timing
- Accept at edge of cycle T (reqN_valid&&reqN_ready high in T).
- EXEC occupies cycles T+1..T+L.
- rsp_valid first high in cycle T+L+1:
  - modes 00 and 01: 2 cycles after accept.
  - mode 10: 3 cycles after accept.
  - mode 11: 4 cycles after accept.
- Handshake in cycle D returns the FSM to IDLE at D+1. The earliest next accept is D+1.
- Minimum period per operation is L+2 cycles, with rsp_ready held high.
- rsp_ready low stalls in DONE indefinitely with no loss.
- busy is registered-state derived: it is 1 from T+1 through the handshake cycle D inclusive, and 0 in D+1.
- No combinational path from rsp_ready to reqN_ready.

## Test plan
- Reset, then a single req0 with mode 00, a=9, b=7:
  - req0_ready high in the same cycle.
  - rsp_valid high 2 cycles later with rsp_out=16, rsp_id=0.
  - ops_count=1 after the handshake.
- Mode 01 with a=3, b=5 → rsp_out=510. Mode 10 with a=15, b=15 → rsp_out=225, with rsp_valid 3 cycles after accept.
- Mode 11 with a=15, x=15, b=15:
  - rsp_out=465 at 4 cycles after accept.
  - A second mode 11 with a=2, x=3, b=1 → 13.
- Both valid continuously with rsp_ready=1:
  - grants alternate 0,1,0,1 starting with 0.
  - rsp_id sequence matches.
  - No ready is asserted while busy=1.
- rsp_ready held low for 5 cycles in DONE:
  - rsp_out and rsp_id are unchanged.
  - Both reqN_ready stay 0.
  - Raising rsp_ready completes exactly one handshake.
- rst_n low for one cycle during mode 11 EXEC:
  - All outputs return to reset values next cycle.
  - No rsp_valid is produced.
  - 256 completed handshakes wrap ops_count to 0.
